m0_mode_input: RTL and testbench
================================

# m0_mode_input

Front-panel input controller that produces the 3-bit mode code consumed by the mode-select display stage. It debounces the five push-buttons and runs a splash / browse / run state machine. Its outputs are the displayed mode number and one-hot enables for the mode sub-blocks. It sits between the board button pins and the seven-segment mode display, in the same IN_CLK domain.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz); must be ≥ 2.
- NUM_MODES, 5: number of selectable modes, which are numbered 1..NUM_MODES; must be ≤ 7.
- IN_CLK  input  1  system clock; the only clock.
- IN_RST  input  1  reset, synchronous, active-high.
- IN_ENABLE  input  1  when low, accepted presses are discarded; the debouncers keep running.
- IN_BTN  input  5  raw buttons, active-high, asynchronous to IN_CLK. Bit 0 = confirm, 1 = up, 4 = down, 2 = back, 3 = unused.
- OUT_MODE  output  3  mode code for the display stage: 0 = select splash, 1..NUM_MODES = mode.
- OUT_RUN  output  1  high while the selected mode is running.
- OUT_MODE_EN  output  8  one-hot of OUT_MODE while OUT_RUN is high, otherwise 0.
- OUT_LED  output  16  bits [4:0] = debounced button levels; bits [15:8] = OUT_MODE_EN; bits [7:5] = 0.

## Operation
- Each button bit passes through a 2-flop synchronizer and then a debouncer.
- Debouncer counter:
  - Increments on every cycle in which the synchronized value differs from the stable level.
  - Clears on any cycle in which the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES−1 and the values still differ, the stable level toggles and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Press pulse: one registered cycle, asserted on each 0→1 transition of the stable level. A held button produces exactly one pulse.
- Press priority within one cycle: confirm > back > up > down. Only the highest-priority press acts; the others are dropped.
- State machine:
  - SPLASH:
    - OUT_MODE = 0, OUT_RUN = 0.
    - Any press (including the unused bit 3) → BROWSE with cursor = 1.
  - BROWSE:
    - OUT_MODE = cursor.
    - Up: cursor+1, wrapping NUM_MODES→1.
    - Down: cursor−1, wrapping 1→NUM_MODES.
    - Confirm → RUN.
    - Back → SPLASH; cursor is kept but not displayed.
  - RUN:
    - OUT_MODE = cursor, OUT_RUN = 1, OUT_MODE_EN = 1 << cursor.
    - Up, down and confirm are ignored.
    - Back → BROWSE.
- IN_ENABLE = 0: press pulses are masked before the state machine, so the state holds.
- Reset:
  - State = SPLASH, cursor = 1.
  - Synchronizers, stable levels, counters and pulses = 0.
  - All outputs = 0.
  - Reset mid-debounce or in RUN aborts immediately, with no pulse emitted.
  - A button held through reset is accepted as a fresh press once DEBOUNCE_CYCLES have elapsed after reset deasserts.

## Timing
- All state changes occur on rising IN_CLK edges; all outputs are registered.
- Press latency: if IN_BTN is first sampled high at edge 1:
  - stable level rises at edge DEBOUNCE_CYCLES+2;
  - press pulse is high after edge DEBOUNCE_CYCLES+3;
  - state, OUT_MODE, OUT_RUN and OUT_MODE_EN update at edge DEBOUNCE_CYCLES+4.
- Release latency: identical, with no pulse and no state change.
- Glitch rejection: a high or low excursion shorter than DEBOUNCE_CYCLES cycles never changes the stable level.
- OUT_LED[4:0] follows the stable levels with 1 cycle of register delay.

## Structure
- Shared package m0_pkg holds:
  - the state enum (SPLASH, BROWSE, RUN);
  - button index constants BTN_OK = 0, BTN_UP = 1, BTN_BACK = 2, BTN_RIGHT = 3, BTN_DOWN = 4;
  - mode code constant MODE_SPLASH = 0.
- Sub-module m0_btn_debounce: synchronizer, counter, stable level and press pulse for one button. It is instantiated five times.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset and first press:
  - Expect OUT_MODE = 0 and all outputs 0 after reset.
  - Hold IN_BTN[1] high from edge 1 → OUT_MODE = 1 at edge 8, no earlier.
- Glitch rejection: 3-cycle pulse on IN_BTN[4] → no state change and OUT_LED[4] stays 0.
- Browse wrap: from cursor 1, press down → OUT_MODE = 5; press up → OUT_MODE = 1.
- Run and back:
  - Confirm at cursor 3 → OUT_RUN = 1, OUT_MODE_EN = 8'h08, OUT_LED[15:8] = 8'h08.
  - Up while running → no change.
  - Back → OUT_RUN = 0, OUT_MODE = 3.
- Simultaneous press: confirm and back rise in the same cycle in BROWSE → RUN entered; back is dropped.
- Enable and reset:
  - IN_ENABLE = 0, press confirm in BROWSE → no change.
  - Reset asserted in RUN → OUT_MODE = 0, OUT_RUN = 0 on the next edge.
  - Button held through reset → press accepted at edge 7 after reset deasserts.

Source files
------------

// File: rtl/m0_pkg.sv
// Shared types and constants for the m0 front-panel mode input controller.
package m0_pkg;

    typedef enum logic [1:0] {
        SPLASH,
        BROWSE,
        RUN
    } state_t;

    localparam int NUM_BTNS  = 5;
    localparam int BTN_OK    = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_BACK  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_DOWN  = 4;

    localparam logic [2:0] MODE_SPLASH = 3'd0;

endpackage

// File: rtl/m0_btn_debounce.sv
// One push-button: 2-flop synchronizer, counting debouncer,
// delayed stable level and single-cycle press pulse.
module m0_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          stable_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn};
            stable_q <= stable;
            press    <= stable & ~stable_q;
            if (sync_q[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = stable_q;

endmodule

// File: rtl/m0_mode_input.sv
// Front-panel controller: debounced buttons drive a splash/browse/run
// state machine producing the mode code and one-hot mode enables.
module m0_mode_input
    import m0_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int NUM_MODES       = 5
) (
    input  logic        IN_CLK,
    input  logic        IN_RST,
    input  logic        IN_ENABLE,
    input  logic [4:0]  IN_BTN,
    output logic [2:0]  OUT_MODE,
    output logic        OUT_RUN,
    output logic [7:0]  OUT_MODE_EN,
    output logic [15:0] OUT_LED
);

    localparam logic [2:0] MODE_MAX = 3'(NUM_MODES);

    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] press_raw;
    logic [NUM_BTNS-1:0] press;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        m0_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (IN_CLK),
            .rst  (IN_RST),
            .btn  (IN_BTN[i]),
            .level(level[i]),
            .press(press_raw[i])
        );
    end

    assign press = press_raw & {NUM_BTNS{IN_ENABLE}};

    state_t     state, state_nxt;
    logic [2:0] cursor, cursor_nxt;
    logic [2:0] mode_nxt;
    logic       run_nxt;
    logic [7:0] en_nxt;
    logic       do_ok, do_back, do_up, do_down;

    // Only the highest-priority press acts: confirm > back > up > down
    always_comb begin
        do_ok   = press[BTN_OK];
        do_back = press[BTN_BACK] & ~do_ok;
        do_up   = press[BTN_UP] & ~do_ok & ~press[BTN_BACK];
        do_down = press[BTN_DOWN] & ~do_ok & ~press[BTN_BACK]
                & ~press[BTN_UP];
    end

    always_comb begin
        state_nxt  = state;
        cursor_nxt = cursor;
        unique case (state)
            SPLASH: begin
                if (|press) begin
                    state_nxt  = BROWSE;
                    cursor_nxt = 3'd1;
                end
            end
            BROWSE: begin
                unique case (1'b1)
                    do_ok:   state_nxt = RUN;
                    do_back: state_nxt = SPLASH;
                    do_up:   cursor_nxt = (cursor == MODE_MAX) ?
                                 3'd1 : cursor + 3'd1;
                    do_down: cursor_nxt = (cursor == 3'd1) ?
                                 MODE_MAX : cursor - 3'd1;
                    default: ;
                endcase
            end
            RUN: begin
                if (do_back) state_nxt = BROWSE;
            end
            default: state_nxt = SPLASH;
        endcase

        mode_nxt = (state_nxt == SPLASH) ? MODE_SPLASH : cursor_nxt;
        run_nxt  = (state_nxt == RUN);
        en_nxt   = run_nxt ? (8'd1 << cursor_nxt) : 8'd0;
    end

    always_ff @(posedge IN_CLK) begin
        if (IN_RST) begin
            state       <= SPLASH;
            cursor      <= 3'd1;
            OUT_MODE    <= MODE_SPLASH;
            OUT_RUN     <= 1'b0;
            OUT_MODE_EN <= 8'd0;
        end else begin
            state       <= state_nxt;
            cursor      <= cursor_nxt;
            OUT_MODE    <= mode_nxt;
            OUT_RUN     <= run_nxt;
            OUT_MODE_EN <= en_nxt;
        end
    end

    assign OUT_LED = {OUT_MODE_EN, 3'b000, level};

endmodule

// File: tb/tb_m0_mode_input.sv
// Directed bench for m0_mode_input with a small expected-result queue.
module tb_m0_mode_input;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [4:0]  btn;
    logic [2:0]  mode;
    logic        run;
    logic [7:0]  mode_en;
    logic [15:0] led;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [2:0] mode;
        logic       run;
        logic [7:0] en;
    } exp_t;

    exp_t sb[$];

    m0_mode_input #(
        .DEBOUNCE_CYCLES(DC),
        .NUM_MODES(5)
    ) dut (
        .IN_CLK     (clk),
        .IN_RST     (rst),
        .IN_ENABLE  (en),
        .IN_BTN     (btn),
        .OUT_MODE   (mode),
        .OUT_RUN    (run),
        .OUT_MODE_EN(mode_en),
        .OUT_LED    (led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_mode"}, 32'(mode), 32'(e.mode));
            chk({e.tag, "_run"}, 32'(run), 32'(e.run));
            chk({e.tag, "_en"}, 32'(mode_en), 32'(e.en));
            chk({e.tag, "_led"}, 32'(led[15:8]), 32'(e.en));
        end
    endtask

    task automatic press(input logic [4:0] mask, input string tag,
                         input logic [2:0] m, input logic r,
                         input logic [7:0] e);
        sb.push_back('{tag: tag, mode: m, run: r, en: e});
        btn = mask;
        repeat (DC + 5) tick();
        pop_chk();
        btn = 5'd0;
        repeat (DC + 5) tick();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        btn = 5'd0;
        repeat (3) tick();
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_en", 32'(mode_en), 32'd0);
        chk("rst_led", 32'(led), 32'd0);

        // first press: IN_BTN[1] sampled high at edge 1
        rst = 1'b0;
        btn = 5'b00010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("first_mode_e%0d", k), 32'(mode),
                (k >= 8) ? 32'd1 : 32'd0);
            chk($sformatf("first_led_e%0d", k), 32'(led[1]),
                (k >= 7) ? 32'd1 : 32'd0);
        end
        btn = 5'd0;
        repeat (DC + 5) tick();

        // 3-cycle glitch on down
        btn = 5'b10000;
        repeat (3) tick();
        btn = 5'd0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("glitch_led_%0d", k), 32'(led[4]), 32'd0);
        end
        chk("glitch_mode", 32'(mode), 32'd1);

        press(5'b10000, "wrap_down", 3'd5, 1'b0, 8'h00);
        press(5'b00010, "wrap_up", 3'd1, 1'b0, 8'h00);
        press(5'b00010, "up2", 3'd2, 1'b0, 8'h00);
        press(5'b00010, "up3", 3'd3, 1'b0, 8'h00);
        press(5'b00001, "run3", 3'd3, 1'b1, 8'h08);
        press(5'b00010, "run_up", 3'd3, 1'b1, 8'h08);
        press(5'b00100, "run_back", 3'd3, 1'b0, 8'h00);
        press(5'b00101, "ok_back", 3'd3, 1'b1, 8'h08);
        press(5'b00100, "back2", 3'd3, 1'b0, 8'h00);

        en = 1'b0;
        press(5'b00001, "disabled", 3'd3, 1'b0, 8'h00);
        en = 1'b1;
        press(5'b00001, "run_again", 3'd3, 1'b1, 8'h08);

        // reset in RUN with confirm held through reset
        btn = 5'b00001;
        rst = 1'b1;
        tick();
        chk("rstrun_mode", 32'(mode), 32'd0);
        chk("rstrun_run", 32'(run), 32'd0);
        chk("rstrun_en", 32'(mode_en), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("held_led_e%0d", k), 32'(led[0]),
                (k >= 7) ? 32'd1 : 32'd0);
            chk($sformatf("held_mode_e%0d", k), 32'(mode),
                (k >= 8) ? 32'd1 : 32'd0);
        end
        btn = 5'd0;
        repeat (DC + 5) tick();
        chk("final_run", 32'(run), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
